// File: rtl/range_arbiter.sv
// range_arbiter: two-requester round-robin session arbiter that measures the
// max-min spread of the samples streamed by the granted requester.
//
// Ports:
//   i_clock        single clock, rising edge
//   i_reset        synchronous, active-high reset
//   i_req[1:0]     level session request per requester
//   i_fin[1:0]     session-end strobe per requester
//   i_data_in      shared sample bus, driven by the granted requester
//   i_data_valid   qualifies i_data_in
//   o_grant[1:0]   one-hot session owner, 0 when no session is open
//   o_range        max-min of the last completed session
//   o_range_valid  one-cycle pulse when o_range updates
//   o_range_owner  requester index that owns o_range
//   o_count[7:0]   accepted samples in current/last session, saturating
//   o_error        sticky fault flag, cleared when the next grant is issued
module range_arbiter #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [1:0]       i_req,
    input  logic [1:0]       i_fin,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_data_valid,
    output logic [1:0]       o_grant,
    output logic [WIDTH-1:0] o_range,
    output logic             o_range_valid,
    output logic             o_range_owner,
    output logic [7:0]       o_count,
    output logic             o_error
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_owner, w_owner_nxt;
    logic             r_last_owner, w_last_owner_nxt;
    logic [WIDTH-1:0] r_max, w_max_nxt;
    logic [WIDTH-1:0] r_min, w_min_nxt;
    logic [7:0]       r_count, w_count_nxt;
    logic [TW-1:0]    r_tmr, w_tmr_nxt;
    logic [1:0]       r_grant, w_grant_nxt;
    logic [WIDTH-1:0] r_range, w_range_nxt;
    logic             r_range_valid, w_range_valid_nxt;
    logic             r_range_owner, w_range_owner_nxt;
    logic             r_error, w_error_nxt;

    // Datapath values with the current sample folded in (if any)
    logic [WIDTH-1:0] w_acc_max;
    logic [WIDTH-1:0] w_acc_min;
    logic [7:0]       w_acc_count;
    logic [TW-1:0]    w_tmr_inc;
    logic             w_sel_owner;

    assign w_acc_max   = (i_data_valid && (i_data_in > r_max)) ? i_data_in : r_max;
    assign w_acc_min   = (i_data_valid && (i_data_in < r_min)) ? i_data_in : r_min;
    assign w_acc_count = (i_data_valid && (r_count != 8'hFF)) ? r_count + 8'd1 : r_count;
    assign w_tmr_inc   = r_tmr + TW'(1);

    // Single request wins outright; a tie goes to the one that did not own last
    assign w_sel_owner = (i_req == 2'b11) ? ~r_last_owner : i_req[1];

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt       = r_state;
        w_owner_nxt       = r_owner;
        w_last_owner_nxt  = r_last_owner;
        w_max_nxt         = r_max;
        w_min_nxt         = r_min;
        w_count_nxt       = r_count;
        w_tmr_nxt         = r_tmr;
        w_grant_nxt       = r_grant;
        w_range_nxt       = r_range;
        w_range_valid_nxt = 1'b0;
        w_range_owner_nxt = r_range_owner;
        w_error_nxt       = r_error;

        case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_state_nxt = S_ACTIVE;
                    w_owner_nxt = w_sel_owner;
                    w_grant_nxt = w_sel_owner ? 2'b10 : 2'b01;
                    w_max_nxt   = '0;
                    w_min_nxt   = '1;
                    w_count_nxt = 8'd0;
                    w_tmr_nxt   = '0;
                    w_error_nxt = 1'b0;
                end
            end

            S_ACTIVE: begin
                w_max_nxt   = w_acc_max;
                w_min_nxt   = w_acc_min;
                w_count_nxt = w_acc_count;
                w_tmr_nxt   = i_data_valid ? '0 : w_tmr_inc;

                if (i_fin[~r_owner]) begin
                    w_error_nxt = 1'b1;
                end

                if (i_fin[r_owner]) begin
                    w_state_nxt       = S_REPORT;
                    w_grant_nxt       = 2'b00;
                    w_range_valid_nxt = 1'b1;
                    w_range_owner_nxt = r_owner;
                    w_last_owner_nxt  = r_owner;
                    // Empty session: report zero rather than 0 - all-ones
                    if (w_acc_count == 8'd0) begin
                        w_range_nxt = '0;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_range_nxt = w_acc_max - w_acc_min;
                    end
                end else if (!i_data_valid && (w_tmr_inc == TW'(TIMEOUT))) begin
                    // Stalled owner: abort without touching the reported range
                    w_state_nxt      = S_IDLE;
                    w_grant_nxt      = 2'b00;
                    w_error_nxt      = 1'b1;
                    w_last_owner_nxt = r_owner;
                end
            end

            S_REPORT: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    // State and register update
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            r_last_owner  <= 1'b1;
            r_max         <= '0;
            r_min         <= '1;
            r_count       <= 8'd0;
            r_tmr         <= '0;
            r_grant       <= 2'b00;
            r_range       <= '0;
            r_range_valid <= 1'b0;
            r_range_owner <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_last_owner  <= w_last_owner_nxt;
            r_max         <= w_max_nxt;
            r_min         <= w_min_nxt;
            r_count       <= w_count_nxt;
            r_tmr         <= w_tmr_nxt;
            r_grant       <= w_grant_nxt;
            r_range       <= w_range_nxt;
            r_range_valid <= w_range_valid_nxt;
            r_range_owner <= w_range_owner_nxt;
            r_error       <= w_error_nxt;
        end
    end

    assign o_grant       = r_grant;
    assign o_range       = r_range;
    assign o_range_valid = r_range_valid;
    assign o_range_owner = r_range_owner;
    assign o_count       = r_count;
    assign o_error       = r_error;

endmodule

// File: tb/tb_range_arbiter.sv
// Directed self-checking bench for range_arbiter (WIDTH=12, TIMEOUT=64).
module tb_range_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  fin;
    logic [11:0] data_in;
    logic        data_valid;
    logic [1:0]  grant;
    logic [11:0] range_o;
    logic        range_valid;
    logic        range_owner;
    logic [7:0]  count;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    range_arbiter #(.WIDTH(12), .TIMEOUT(64)) dut (
        .i_clock      (clk),
        .i_reset      (reset),
        .i_req        (req),
        .i_fin        (fin),
        .i_data_in    (data_in),
        .i_data_valid (data_valid),
        .o_grant      (grant),
        .o_range      (range_o),
        .o_range_valid(range_valid),
        .o_range_owner(range_owner),
        .o_count      (count),
        .o_error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 2'b00; fin = 2'b00; data_in = 12'd0; data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick(); tick();
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got=%0d exp=0", grant); end
        n_checks++; if (range_o !== 12'd0) begin n_fail++; $display("FAIL reset_range got=%0d exp=0", range_o); end
        n_checks++; if (range_valid !== 1'b0) begin n_fail++; $display("FAIL reset_range_valid got=%0d exp=0", range_valid); end
        n_checks++; if (range_owner !== 1'b0) begin n_fail++; $display("FAIL reset_range_owner got=%0d exp=0", range_owner); end
        n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%0d exp=0", error); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        req = 2'b01;
        tick();
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL basic_grant got=%0d exp=1", grant); end
        req = 2'b00;
        data_valid = 1'b1;
        data_in = 12'd5;   tick();
        data_in = 12'd900; tick();
        data_in = 12'd17;  tick();
        data_valid = 1'b0;
        fin = 2'b01;
        tick();
        fin = 2'b00;
        n_checks++; if (range_o !== 12'd895) begin n_fail++; $display("FAIL basic_range got=%0d exp=895", range_o); end
        n_checks++; if (range_valid !== 1'b1) begin n_fail++; $display("FAIL basic_range_valid got=%0d exp=1", range_valid); end
        n_checks++; if (range_owner !== 1'b0) begin n_fail++; $display("FAIL basic_range_owner got=%0d exp=0", range_owner); end
        n_checks++; if (count !== 8'd3) begin n_fail++; $display("FAIL basic_count got=%0d exp=3", count); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error got=%0d exp=0", error); end
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL basic_grant_drop got=%0d exp=0", grant); end
        tick();
        n_checks++; if (range_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_pulse got=%0d exp=0", range_valid); end
        n_checks++; if (range_o !== 12'd895) begin n_fail++; $display("FAIL basic_range_hold got=%0d exp=895", range_o); end
    endtask

    task automatic test_round_robin();
        test_reset();
        req = 2'b11;
        tick();
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rr_first_grant got=%0d exp=1", grant); end
        data_in = 12'd8; data_valid = 1'b1; fin = 2'b01;
        tick();
        data_valid = 1'b0; fin = 2'b00;
        n_checks++; if (range_valid !== 1'b1) begin n_fail++; $display("FAIL rr_first_report got=%0d exp=1", range_valid); end
        tick();
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rr_idle_gap got=%0d exp=0", grant); end
        tick();
        n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rr_second_grant got=%0d exp=2", grant); end
        req = 2'b00;
        data_in = 12'd9; data_valid = 1'b1; fin = 2'b10;
        tick();
        data_valid = 1'b0; fin = 2'b00;
        n_checks++; if (range_o !== 12'd0) begin n_fail++; $display("FAIL rr_range got=%0d exp=0", range_o); end
        n_checks++; if (range_owner !== 1'b1) begin n_fail++; $display("FAIL rr_range_owner got=%0d exp=1", range_owner); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rr_error got=%0d exp=0", error); end
        tick();
    endtask

    task automatic test_empty_fin();
        req = 2'b01;
        tick();
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL empty_grant got=%0d exp=1", grant); end
        req = 2'b00; fin = 2'b01;
        tick();
        fin = 2'b00;
        n_checks++; if (range_o !== 12'd0) begin n_fail++; $display("FAIL empty_range got=%0d exp=0", range_o); end
        n_checks++; if (range_valid !== 1'b1) begin n_fail++; $display("FAIL empty_range_valid got=%0d exp=1", range_valid); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL empty_error got=%0d exp=1", error); end
        n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL empty_count got=%0d exp=0", count); end
        tick();
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL empty_error_sticky got=%0d exp=1", error); end
        req = 2'b01;
        tick();
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL empty_error_clear got=%0d exp=0", error); end
        req = 2'b00;
        data_in = 12'd3; data_valid = 1'b1; fin = 2'b01;
        tick();
        data_valid = 1'b0; fin = 2'b00;
        n_checks++; if (count !== 8'd1) begin n_fail++; $display("FAIL empty_fin_sample_count got=%0d exp=1", count); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL empty_fin_sample_error got=%0d exp=0", error); end
        tick();
    endtask

    task automatic test_nonowner_fin();
        req = 2'b10;
        tick();
        n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL nonown_grant got=%0d exp=2", grant); end
        req = 2'b00; fin = 2'b01;
        tick();
        fin = 2'b00;
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL nonown_error got=%0d exp=1", error); end
        n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL nonown_continue got=%0d exp=2", grant); end
        data_valid = 1'b1;
        data_in = 12'd100; tick();
        data_in = 12'd40;  tick();
        data_valid = 1'b0; fin = 2'b10;
        tick();
        fin = 2'b00;
        n_checks++; if (range_o !== 12'd60) begin n_fail++; $display("FAIL nonown_range got=%0d exp=60", range_o); end
        n_checks++; if (range_owner !== 1'b1) begin n_fail++; $display("FAIL nonown_range_owner got=%0d exp=1", range_owner); end
        n_checks++; if (range_valid !== 1'b1) begin n_fail++; $display("FAIL nonown_range_valid got=%0d exp=1", range_valid); end
        n_checks++; if (count !== 8'd2) begin n_fail++; $display("FAIL nonown_count got=%0d exp=2", count); end
        tick();
    endtask

    task automatic test_timeout();
        req = 2'b01;
        tick();
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL tmo_grant got=%0d exp=1", grant); end
        req = 2'b00;
        data_in = 12'd7; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 63; i++) tick();
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL tmo_before_limit got=%0d exp=1", grant); end
        tick();
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL tmo_grant_drop got=%0d exp=0", grant); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL tmo_error got=%0d exp=1", error); end
        n_checks++; if (range_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_range_valid got=%0d exp=0", range_valid); end
        n_checks++; if (range_o !== 12'd60) begin n_fail++; $display("FAIL tmo_range_hold got=%0d exp=60", range_o); end
        n_checks++; if (count !== 8'd1) begin n_fail++; $display("FAIL tmo_count got=%0d exp=1", count); end
        // Aborted owner 0 becomes last owner, so a tie now goes to requester 1
        req = 2'b11;
        tick();
        n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL tmo_next_rr got=%0d exp=2", grant); end
        req = 2'b00; fin = 2'b10;
        tick();
        fin = 2'b00;
        tick();
    endtask

    task automatic test_reset_active();
        req = 2'b01;
        tick();
        req = 2'b00;
        data_valid = 1'b1;
        data_in = 12'd1; tick();
        data_in = 12'd2; tick();
        data_valid = 1'b0;
        n_checks++; if (count !== 8'd2) begin n_fail++; $display("FAIL rst_act_count_pre got=%0d exp=2", count); end
        reset = 1'b1;
        tick();
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_act_grant got=%0d exp=0", grant); end
        n_checks++; if (range_o !== 12'd0) begin n_fail++; $display("FAIL rst_act_range got=%0d exp=0", range_o); end
        n_checks++; if (range_valid !== 1'b0) begin n_fail++; $display("FAIL rst_act_range_valid got=%0d exp=0", range_valid); end
        n_checks++; if (range_owner !== 1'b0) begin n_fail++; $display("FAIL rst_act_range_owner got=%0d exp=0", range_owner); end
        n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL rst_act_count got=%0d exp=0", count); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_act_error got=%0d exp=0", error); end
        reset = 1'b0;
        tick();
        n_checks++; if (range_valid !== 1'b0) begin n_fail++; $display("FAIL rst_act_no_pulse got=%0d exp=0", range_valid); end
        // fin while idle is ignored and raises no fault
        fin = 2'b11;
        tick();
        fin = 2'b00;
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL idle_fin_error got=%0d exp=0", error); end
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL idle_fin_grant got=%0d exp=0", grant); end
        // Reset restores last_owner=1, so requester 0 wins the tie
        req = 2'b11;
        tick();
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rst_tie_grant got=%0d exp=1", grant); end
        req = 2'b00; fin = 2'b01;
        tick();
        fin = 2'b00;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_round_robin();
        test_empty_fin();
        test_nonowner_fin();
        test_timeout();
        test_reset_active();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
